// File: rtl/wb_pkg.sv
// ---- wb_pkg : shared Wishbone widths, request capture type and slave FSM states (rev 1.0) ----
`default_nettype none

package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef struct packed {
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
    logic                we;
  } wb_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_slv_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_bus_if.sv
// ---- wb_bus_t : Wishbone classic bus bundle with master and slave views (rev 1.0) ----
`default_nettype none

interface wb_bus_t;
  import wb_pkg::*;

  logic                wb_cyc;
  logic                wb_stb;
  logic                wb_we;
  logic [WB_SEL_W-1:0] wb_sel;
  logic [WB_ADR_W-1:0] wb_adr;
  logic [WB_DAT_W-1:0] wb_dat_ms;
  logic [WB_DAT_W-1:0] wb_dat_sm;
  logic                wb_ack;

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms,
    output wb_dat_sm, wb_ack
  );

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms,
    input  wb_dat_sm, wb_ack
  );

endinterface

`default_nettype wire

// File: rtl/wb_ram_slave_mem.sv
// ---- wb_ram_slave_mem : single-port synchronous word RAM, byte-lane writes, 1-cycle read (rev 1.0) ----
`default_nettype none

module wb_ram_slave_mem
  import wb_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [WB_SEL_W-1:0] sel,
  input  logic [AW-1:0]       addr,
  input  logic [WB_DAT_W-1:0] wdata,
  output logic [WB_DAT_W-1:0] rdata
);

  logic [WB_DAT_W-1:0] r_mem [DEPTH_WORDS];
  logic [WB_DAT_W-1:0] r_rdata;

  // Read register only moves on reads so the slave can hold it across write acks.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < WB_SEL_W; i++) begin
          if (sel[i]) begin
            r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/wb_ram_slave.sv
// ---- wb_ram_slave : Wishbone slave with window decode and wait states over on-chip RAM (rev 1.0) ----
`default_nettype none

module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic    clk,
  input  logic    rstn_i,
  wb_bus_t.slave  wb_bus,
  output logic    oor_o,
  output logic    busy_o
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [32:0] C_BASE      = {1'b0, BASE_ADDR};
  localparam logic [32:0] C_LIMIT     = C_BASE + 33'(4 * DEPTH_WORDS);
  localparam int          C_WAIT_INT  = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
  localparam logic [3:0]  C_WAIT_LOAD = C_WAIT_INT[3:0];

  wb_slv_state_t       r_state;
  wb_slv_state_t       w_state_nxt;
  logic [3:0]          r_wait_cnt;
  wb_req_t             r_req;
  wb_req_t             w_cur;
  logic                r_oor;
  logic                r_rd_zero;
  logic                w_req;
  logic                w_enter_ack;
  logic [32:0]         w_adr_ext;
  logic [32:0]         w_off;
  logic                w_in_range;
  logic [WB_DAT_W-1:0] w_mem_rdata;
  logic                w_unused;

  assign w_req = wb_bus.wb_cyc & wb_bus.wb_stb;

  // In IDLE the live bus feeds the RAM so a zero-wait transfer commits on its capture edge.
  always_comb begin
    w_cur = r_req;
    if (r_state == ST_IDLE) begin
      w_cur.adr = wb_bus.wb_adr;
      w_cur.dat = wb_bus.wb_dat_ms;
      w_cur.sel = wb_bus.wb_sel;
      w_cur.we  = wb_bus.wb_we;
    end
  end

  // 33-bit compare keeps a window ending exactly at 2^32 from wrapping.
  assign w_adr_ext  = {1'b0, w_cur.adr};
  assign w_off      = w_adr_ext - C_BASE;
  assign w_in_range = (w_adr_ext >= C_BASE) && (w_adr_ext < C_LIMIT);
  assign w_unused   = ^{w_off[32:AW+2], w_off[1:0]};

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (r_wait_cnt == 4'd0) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_enter_ack = (w_state_nxt == ST_ACK);

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wait_cnt <= 4'd0;
      r_req      <= '0;
      r_oor      <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else begin
      if ((r_state == ST_IDLE) && w_req) begin
        r_wait_cnt <= C_WAIT_LOAD;
        r_req      <= w_cur;
      end else if ((r_state == ST_WAIT) && w_req && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (w_enter_ack) begin
        r_oor <= !w_in_range;
        if (!w_cur.we) begin
          r_rd_zero <= !w_in_range;
        end
      end
    end
  end

  wb_ram_slave_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .en    (w_enter_ack & w_in_range & rstn_i),
    .we    (w_cur.we),
    .sel   (w_cur.sel),
    .addr  (w_off[AW+1:2]),
    .wdata (w_cur.dat),
    .rdata (w_mem_rdata)
  );

  assign wb_bus.wb_ack    = (r_state == ST_ACK);
  assign wb_bus.wb_dat_sm = r_rd_zero ? '0 : w_mem_rdata;
  assign oor_o            = (r_state == ST_ACK) & r_oor;
  assign busy_o           = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_wb_ram_slave.sv
// ---- tb_wb_ram_slave : directed bench for wb_ram_slave across four parameter sets (rev 1.0) ----
`default_nettype none

module tb_wb_ram_slave;
  import wb_pkg::*;

  localparam int N_DUT = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        cyc  [N_DUT];
  logic        stb  [N_DUT];
  logic        we   [N_DUT];
  logic [3:0]  sel  [N_DUT];
  logic [31:0] adr  [N_DUT];
  logic [31:0] dms  [N_DUT];
  logic        ack  [N_DUT];
  logic [31:0] dsm  [N_DUT];
  logic        oor  [N_DUT];
  logic        busy [N_DUT];

  int n_checks = 0;
  int n_fail   = 0;

  // DUT0: WS=1 base 0 | DUT1: WS=3 base 0 | DUT2: WS=2 base 0x1000 | DUT3: WS=0 depth 16
  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    wb_bus_t bus ();
    assign bus.wb_cyc    = cyc[g];
    assign bus.wb_stb    = stb[g];
    assign bus.wb_we     = we[g];
    assign bus.wb_sel    = sel[g];
    assign bus.wb_adr    = adr[g];
    assign bus.wb_dat_ms = dms[g];
    assign ack[g]        = bus.wb_ack;
    assign dsm[g]        = bus.wb_dat_sm;

    wb_ram_slave #(
      .DEPTH_WORDS ((g == 3) ? 16 : 64),
      .BASE_ADDR   ((g == 2) ? 32'h0000_1000 : 32'h0),
      .WAIT_STATES ((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 0),
      .INIT_FILE   ("")
    ) u_dut (
      .clk    (clk),
      .rstn_i (rstn),
      .wb_bus (bus),
      .oor_o  (oor[g]),
      .busy_o (busy[g])
    );
  end

  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, output logic [31:0] rd, output int lat,
                      output logic oor_seen);
    rd = 32'h0;
    lat = -1;
    oor_seen = 1'b0;
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dms[d] = wd; sel[d] = s;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack[d]) begin
        lat = i;
        rd = dsm[d];
        oor_seen = oor[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    for (int d = 0; d < N_DUT; d++) begin
      n_checks += 4;
      if (ack[d] !== 1'b0) begin $display("FAIL reset_ack dut%0d: got %b expected 0", d, ack[d]); n_fail++; end
      if (busy[d] !== 1'b0) begin $display("FAIL reset_busy dut%0d: got %b expected 0", d, busy[d]); n_fail++; end
      if (oor[d] !== 1'b0) begin $display("FAIL reset_oor dut%0d: got %b expected 0", d, oor[d]); n_fail++; end
      if (dsm[d] !== 32'h0) begin $display("FAIL reset_dat dut%0d: got %h expected 00000000", d, dsm[d]); n_fail++; end
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; int lat; logic o;
    xfer(0, 1'b1, 32'h10, 32'hA5A5_1234, 4'hF, rd, lat, o);
    n_checks += 3;
    if (lat != 2) begin $display("FAIL wr_latency: got %0d expected 2", lat); n_fail++; end
    if (o !== 1'b0) begin $display("FAIL wr_oor: got %b expected 0", o); n_fail++; end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, o);
    if (lat != 2) begin $display("FAIL rd_latency: got %0d expected 2", lat); n_fail++; end
    n_checks++;
    if (rd !== 32'hA5A5_1234) begin $display("FAIL rd_data: got %h expected a5a51234", rd); n_fail++; end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks += 2;
      if (dsm[0] !== 32'hA5A5_1234) begin $display("FAIL dat_hold: got %h expected a5a51234", dsm[0]); n_fail++; end
      if (ack[0] !== 1'b0) begin $display("FAIL ack_single: got %b expected 0", ack[0]); n_fail++; end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int lat; logic o;
    xfer(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, rd, lat, o);
    xfer(0, 1'b1, 32'h20, 32'h0000_0000, 4'b0101, rd, lat, o);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, lat, o);
    n_checks++;
    if (rd !== 32'hFF00_FF00) begin $display("FAIL byte_lane: got %h expected ff00ff00", rd); n_fail++; end
    xfer(0, 1'b1, 32'h20, 32'h1234_5678, 4'b0000, rd, lat, o);
    n_checks++;
    if (lat != 2) begin $display("FAIL sel0_ack: got latency %0d expected 2", lat); n_fail++; end
    xfer(0, 1'b0, 32'h22, 32'h0, 4'b0001, rd, lat, o);
    n_checks++;
    if (rd !== 32'hFF00_FF00) begin $display("FAIL sel0_nochange: got %h expected ff00ff00", rd); n_fail++; end
  endtask

  task automatic test_abort();
    logic [31:0] rd; int lat; logic o; logic seen;
    xfer(1, 1'b1, 32'h30, 32'h1111_2222, 4'hF, rd, lat, o);
    n_checks++;
    if (lat != 4) begin $display("FAIL ws3_latency: got %0d expected 4", lat); n_fail++; end
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h30; dms[1] = 32'hDEAD_BEEF; sel[1] = 4'hF;
    @(posedge clk); #1;
    n_checks++;
    if (busy[1] !== 1'b1) begin $display("FAIL abort_busy: got %b expected 1", busy[1]); n_fail++; end
    stb[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack[1]) seen = 1'b1;
    end
    cyc[1] = 1'b0; we[1] = 1'b0;
    n_checks += 2;
    if (seen !== 1'b0) begin $display("FAIL abort_ack: got ack %b expected 0", seen); n_fail++; end
    if (busy[1] !== 1'b0) begin $display("FAIL abort_idle: got busy %b expected 0", busy[1]); n_fail++; end
    xfer(1, 1'b0, 32'h30, 32'h0, 4'hF, rd, lat, o);
    n_checks++;
    if (rd !== 32'h1111_2222) begin $display("FAIL abort_nowrite: got %h expected 11112222", rd); n_fail++; end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, rd1, rd2; int lat; logic o; int t1, gap;
    xfer(0, 1'b1, 32'h40, 32'h4040_4040, 4'hF, rd, lat, o);
    xfer(0, 1'b1, 32'h44, 32'h4444_4444, 4'hF, rd, lat, o);
    @(posedge clk); #1;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h40; sel[0] = 4'hF;
    t1 = -1; gap = -1; rd1 = 32'h0; rd2 = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack[0]) begin
        if (t1 < 0) begin
          t1 = i; rd1 = dsm[0]; adr[0] = 32'h44;
        end else begin
          gap = i - t1; rd2 = dsm[0];
          break;
        end
      end
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    n_checks += 3;
    if (rd1 !== 32'h4040_4040) begin $display("FAIL b2b_data0: got %h expected 40404040", rd1); n_fail++; end
    if (rd2 !== 32'h4444_4444) begin $display("FAIL b2b_data1: got %h expected 44444444", rd2); n_fail++; end
    if (gap != 3) begin $display("FAIL b2b_gap: got %0d edges expected 3", gap); n_fail++; end
    @(posedge clk); #1;
    n_checks++;
    if (ack[0] !== 1'b0) begin $display("FAIL b2b_no_dup: got %b expected 0", ack[0]); n_fail++; end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; int lat; logic o;
    xfer(2, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, rd, lat, o);
    xfer(2, 1'b1, 32'h10FC, 32'h0BAD_BEEF, 4'hF, rd, lat, o);
    n_checks++;
    if (o !== 1'b0) begin $display("FAIL oor_top_inrange: got %b expected 0", o); n_fail++; end
    xfer(2, 1'b0, 32'h1000, 32'h0, 4'hF, rd, lat, o);
    n_checks += 2;
    if (rd !== 32'hCAFE_F00D) begin $display("FAIL oor_base_data: got %h expected cafef00d", rd); n_fail++; end
    if (lat != 3) begin $display("FAIL ws2_latency: got %0d expected 3", lat); n_fail++; end
    xfer(2, 1'b0, 32'h0FFC, 32'h0, 4'hF, rd, lat, o);
    n_checks += 3;
    if (lat != 3) begin $display("FAIL oor_below_ack: got latency %0d expected 3", lat); n_fail++; end
    if (rd !== 32'h0) begin $display("FAIL oor_below_data: got %h expected 00000000", rd); n_fail++; end
    if (o !== 1'b1) begin $display("FAIL oor_below_flag: got %b expected 1", o); n_fail++; end
    xfer(2, 1'b0, 32'h1100, 32'h0, 4'hF, rd, lat, o);
    n_checks += 2;
    if (rd !== 32'h0) begin $display("FAIL oor_above_data: got %h expected 00000000", rd); n_fail++; end
    if (o !== 1'b1) begin $display("FAIL oor_above_flag: got %b expected 1", o); n_fail++; end
    @(posedge clk); #1;
    n_checks++;
    if (oor[2] !== 1'b0) begin $display("FAIL oor_pulse: got %b expected 0", oor[2]); n_fail++; end
    xfer(2, 1'b1, 32'h0FFC, 32'hFFFF_FFFF, 4'hF, rd, lat, o);
    n_checks++;
    if (o !== 1'b1) begin $display("FAIL oor_wr_flag: got %b expected 1", o); n_fail++; end
    xfer(2, 1'b1, 32'h1100, 32'hFFFF_FFFF, 4'hF, rd, lat, o);
    xfer(2, 1'b0, 32'h1000, 32'h0, 4'hF, rd, lat, o);
    n_checks++;
    if (rd !== 32'hCAFE_F00D) begin $display("FAIL oor_wr_base: got %h expected cafef00d", rd); n_fail++; end
    xfer(2, 1'b0, 32'h10FC, 32'h0, 4'hF, rd, lat, o);
    n_checks++;
    if (rd !== 32'h0BAD_BEEF) begin $display("FAIL oor_wr_top: got %h expected 0badbeef", rd); n_fail++; end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; int lat; logic o;
    xfer(3, 1'b1, 32'h8, 32'h0000_0077, 4'hF, rd, lat, o);
    n_checks++;
    if (lat != 1) begin $display("FAIL ws0_wr_latency: got %0d expected 1", lat); n_fail++; end
    xfer(3, 1'b0, 32'h8, 32'h0, 4'hF, rd, lat, o);
    n_checks += 2;
    if (lat != 1) begin $display("FAIL ws0_rd_latency: got %0d expected 1", lat); n_fail++; end
    if (rd !== 32'h0000_0077) begin $display("FAIL ws0_data: got %h expected 00000077", rd); n_fail++; end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; int lat; logic o;
    xfer(1, 1'b1, 32'h34, 32'h0000_0055, 4'hF, rd, lat, o);
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h34; dms[1] = 32'h0000_0099; sel[1] = 4'hF;
    @(posedge clk); #1;
    n_checks++;
    if (busy[1] !== 1'b1) begin $display("FAIL rst_pre_busy: got %b expected 1", busy[1]); n_fail++; end
    rstn = 1'b0;
    #1;
    n_checks += 2;
    if (busy[1] !== 1'b0) begin $display("FAIL rst_busy: got %b expected 0", busy[1]); n_fail++; end
    if (ack[1] !== 1'b0) begin $display("FAIL rst_ack: got %b expected 0", ack[1]); n_fail++; end
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    xfer(1, 1'b0, 32'h34, 32'h0, 4'hF, rd, lat, o);
    n_checks++;
    if (rd !== 32'h0000_0055) begin $display("FAIL rst_nowrite: got %h expected 00000055", rd); n_fail++; end
  endtask

  initial begin
    for (int d = 0; d < N_DUT; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0; adr[d] = 32'h0; dms[d] = 32'h0;
    end
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_abort();
    test_back_to_back();
    test_out_of_range();
    test_zero_wait();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
